// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide execute unit.
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Radix-2 restoring divider datapath: one quotient bit per step on unsigned magnitudes.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // rem_q < divisor holds between steps, so bit XLEN of diff is the borrow.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    quot_nxt = '0;
    rem_nxt  = '0;
    if (!diff[XLEN]) begin
      rem_nxt  = diff[XLEN-1:0];
      quot_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt  = shifted[XLEN-1:0];
      quot_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (clr) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quot_nxt;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M execute unit: 2-cycle multiplier, 32-step restoring divider, busy-based stall.
// Optional MDU_DIV_SHORTCUT_EN: divide-by-zero / signed overflow bypass the divider.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic [XLEN-1:0]     a_q, b_q, res_q;
  logic [2:0]          f3_q;
  logic                accept, last_step, special_in;
  logic [XLEN-1:0]     special_res;

  logic                sgn_a, sgn_b;
  logic [XLEN:0]       a_ext, b_ext;
  logic signed [2*XLEN+1:0] prod;
  logic [XLEN-1:0]     mul_res;

  logic [XLEN-1:0]     quot_nxt, rem_nxt;
  logic                div_signed, b_zero, div_ovf;
  logic [XLEN-1:0]     q_fix, r_fix, div_res;

  assign accept    = in_valid && (state == ST_IDLE) && !flush;
  assign last_step = (state == ST_DIV) && (cnt == CNT_W'(XLEN-1));

`ifdef MDU_DIV_SHORTCUT_EN
  assign special_in = func3[2] &&
                      ((op_b == '0) || (!func3[0] && (op_a == XMIN) && (op_b == '1)));
`else
  assign special_in = 1'b0;
`endif
  assign special_res = (op_b == '0) ? (func3[1] ? op_a : '1)
                                    : (func3[1] ? '0   : XMIN);

  // Multiplier: both operands widened to 33 bits so every variant is one signed product.
  always_comb begin
    sgn_a   = (f3_q == MDU_MULH) || (f3_q == MDU_MULHSU);
    sgn_b   = (f3_q == MDU_MULH);
    a_ext   = {sgn_a & a_q[XLEN-1], a_q};
    b_ext   = {sgn_b & b_q[XLEN-1], b_q};
    prod    = $signed(a_ext) * $signed(b_ext);
    mul_res = (f3_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Sign correction and special-case override on the final divider step.
  always_comb begin
    div_signed = !f3_q[0];
    b_zero     = (b_q == '0);
    div_ovf    = div_signed && (a_q == XMIN) && (b_q == '1);
    q_fix      = (div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? (~quot_nxt + 1'b1) : quot_nxt;
    r_fix      = (div_signed && a_q[XLEN-1]) ? (~rem_nxt + 1'b1) : rem_nxt;
    if (b_zero) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (div_ovf) begin
      q_fix = XMIN;
      r_fix = '0;
    end
    div_res = f3_q[1] ? r_fix : q_fix;
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (accept && func3[2] && !special_in),
    .step     ((state == ST_DIV) && !flush),
    .dividend (mag32(op_a, !func3[0])),
    .divisor  (mag32(op_b, !func3[0])),
    .quot_nxt (quot_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (in_valid) state_nxt = !func3[2] ? ST_MUL : (special_in ? ST_DONE : ST_DIV);
        ST_MUL:  state_nxt = ST_DONE;
        ST_DIV:  if (last_step) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    busy      = (in_valid && (state == ST_IDLE) && !flush) ||
                (state == ST_MUL) || (state == ST_DIV);
    out_valid = (state == ST_DONE) && !flush;
    result    = res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      res_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (in_valid) begin
          a_q  <= op_a;
          b_q  <= op_b;
          f3_q <= func3;
          cnt  <= '0;
          if (special_in) res_q <= special_res;
        end
        ST_MUL: res_q <= mul_res;
        ST_DIV: begin
          cnt <= cnt + 1'b1;
          if (last_step) res_q <= div_res;
        end
        default: ;
      endcase
    end
  end

endmodule
